// File: rtl/rdma_burst_engine.sv
// rdma_burst_engine: AXI4 read-DMA engine. Fetches transfer_byte bytes from
// base_addr as INCR bursts that never cross a 4 KB page, keeps up to
// MAX_OUTSTANDING bursts in flight and forwards read data on a valid/ready
// stream with full backpressure.
//
// Optional feature macro: RDMA_RRESP_CHECK_EN
//   defined   -> any R beat with RRESP != OKAY sets the sticky err flag,
//                cleared by the next accepted launch or by rst.
//   undefined -> err is tied low and RRESP is ignored.
module rdma_burst_engine #(
    parameter int DATA_W          = 64,
    parameter int ADDR_W          = 32,
    parameter int MAX_BURST       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       transfer_byte,
    output logic              busy,
    output logic              done,
    output logic              err,

    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,

    output logic              m_axi_ARVALID,
    input  logic              m_axi_ARREADY,
    output logic [ADDR_W-1:0] m_axi_ARADDR,
    output logic [7:0]        m_axi_ARLEN,
    output logic [2:0]        m_axi_ARSIZE,
    output logic [1:0]        m_axi_ARBURST,
    output logic [3:0]        m_axi_ARID,
    output logic [3:0]        m_axi_ARCACHE,
    output logic [2:0]        m_axi_ARPROT,
    output logic [3:0]        m_axi_ARQOS,

    input  logic              m_axi_RVALID,
    output logic              m_axi_RREADY,
    input  logic [DATA_W-1:0] m_axi_RDATA,
    input  logic              m_axi_RLAST,
    input  logic [1:0]        m_axi_RRESP
);

    localparam int BYTES     = DATA_W / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              start_prev;
    logic              launch_req;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        arlen_q;
    logic [31:0]       beats_left;
    logic [31:0]       beats_rx;
    logic [OUT_W-1:0]  outstanding;
    logic              done_q;

    // Beats in the next burst: limited by what is left, the burst cap and
    // the distance to the next 4 KB page boundary.
    function automatic logic [31:0] burst_len(input logic [31:0] beats,
                                              input logic [11:0] page_offs);
        logic [31:0] room;
        logic [31:0] len;
        room = (32'd4096 - {20'd0, page_offs}) >> SIZE_LOG2;
        len  = beats;
        if (len > 32'(MAX_BURST)) len = 32'(MAX_BURST);
        if (len > room)           len = room;
        return len;
    endfunction

    function automatic logic [7:0] to_arlen(input logic [31:0] len);
        return (len == 32'd0) ? 8'd0 : 8'(len - 32'd1);
    endfunction

    logic [31:0]       launch_beats;
    logic [31:0]       launch_len;
    logic [31:0]       cur_len;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       next_beats;
    logic [31:0]       next_len;
    logic              launch;
    logic              ar_hs;
    logic              r_hs;
    logic              rlast_hs;

    assign launch_beats = transfer_byte >> SIZE_LOG2;
    assign launch_len   = burst_len(launch_beats, base_addr[11:0]);
    assign cur_len      = {24'd0, arlen_q} + 32'd1;
    assign next_addr    = addr_q + ADDR_W'(cur_len << SIZE_LOG2);
    assign next_beats   = beats_left - cur_len;
    assign next_len     = burst_len(next_beats, next_addr[11:0]);

    assign launch   = (state == S_IDLE) && launch_req;
    assign ar_hs    = m_axi_ARVALID && m_axi_ARREADY;
    assign r_hs     = m_axi_RVALID && m_axi_RREADY;
    assign rlast_hs = r_hs && m_axi_RLAST;

    // Registered rising-edge detect on start; edges seen outside IDLE are dropped.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every state register uses <= so all flops sample pre-edge values
        // regardless of block ordering; mixing in = here would create races.
        if (rst) begin
            start_prev <= 1'b0;
            launch_req <= 1'b0;
        end else begin
            start_prev <= start;
            launch_req <= start && !start_prev && (state == S_IDLE);
        end
    end

    // Main FSM plus the registered AR address/length for the burst on offer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            arlen_q    <= 8'd0;
            beats_left <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch_req) begin
                        addr_q     <= base_addr;
                        beats_left <= launch_beats;
                        arlen_q    <= to_arlen(launch_len);
                        state      <= (launch_beats == 32'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ar_hs) begin
                        addr_q     <= next_addr;
                        beats_left <= next_beats;
                        if (next_beats == 32'd0) begin
                            state <= S_DRAIN;
                        end else begin
                            arlen_q <= to_arlen(next_len);
                        end
                    end
                end
                S_DRAIN: begin
                    if (rlast_hs && beats_rx == 32'd1) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // In-flight burst count and remaining beat count for the R side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            beats_rx    <= 32'd0;
        end else if (launch) begin
            outstanding <= '0;
            beats_rx    <= launch_beats;
        end else begin
            if (r_hs) beats_rx <= beats_rx - 32'd1;
            case ({ar_hs, rlast_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // One-cycle completion pulse, issued the cycle after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= (state == S_DONE);
    end

`ifdef RDMA_RRESP_CHECK_EN
    logic err_q;

    // Sticky error on any non-OKAY read response; a new launch clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              err_q <= 1'b0;
        else if (launch)                      err_q <= 1'b0;
        else if (r_hs && m_axi_RRESP != 2'b00) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic rresp_unused;
    assign rresp_unused = ^m_axi_RRESP;
    assign err          = 1'b0;
`endif

    assign busy = (state != S_IDLE);
    assign done = done_q;

    assign m_axi_ARVALID = (state == S_ISSUE) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign m_axi_ARADDR  = addr_q;
    assign m_axi_ARLEN   = arlen_q;
    assign m_axi_ARSIZE  = 3'(SIZE_LOG2);
    assign m_axi_ARBURST = 2'b01;
    assign m_axi_ARID    = 4'd0;
    assign m_axi_ARCACHE = 4'd0;
    assign m_axi_ARPROT  = 3'd0;
    assign m_axi_ARQOS   = 4'd0;

    // The read path is a straight wire gated by busy.
    assign out_data     = m_axi_RDATA;
    assign out_valid    = m_axi_RVALID && busy;
    assign m_axi_RREADY = out_ready && busy;

endmodule

// File: tb/tb_rdma_burst_engine.sv
// Directed testbench for rdma_burst_engine (DATA_W=64, MAX_BURST=32,
// MAX_OUTSTANDING=2). A small AXI slave model serves R beats whose data is a
// function of the beat address, so order and content can be checked.
module tb_rdma_burst_engine;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 32;
    localparam int MAX_BUR = 32;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] transfer_byte;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        m_axi_ARVALID;
    logic        m_axi_ARREADY;
    logic [31:0] m_axi_ARADDR;
    logic [7:0]  m_axi_ARLEN;
    logic [2:0]  m_axi_ARSIZE;
    logic [1:0]  m_axi_ARBURST;
    logic [3:0]  m_axi_ARID;
    logic [3:0]  m_axi_ARCACHE;
    logic [2:0]  m_axi_ARPROT;
    logic [3:0]  m_axi_ARQOS;
    logic        m_axi_RVALID;
    logic        m_axi_RREADY;
    logic [63:0] m_axi_RDATA;
    logic        m_axi_RLAST;
    logic [1:0]  m_axi_RRESP;

    rdma_burst_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BUR), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .transfer_byte(transfer_byte), .busy(busy), .done(done), .err(err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARREADY(m_axi_ARREADY),
        .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARLEN(m_axi_ARLEN),
        .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST),
        .m_axi_ARID(m_axi_ARID), .m_axi_ARCACHE(m_axi_ARCACHE),
        .m_axi_ARPROT(m_axi_ARPROT), .m_axi_ARQOS(m_axi_ARQOS),
        .m_axi_RVALID(m_axi_RVALID), .m_axi_RREADY(m_axi_RREADY),
        .m_axi_RDATA(m_axi_RDATA), .m_axi_RLAST(m_axi_RLAST), .m_axi_RRESP(m_axi_RRESP)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Slave model state and observation logs.
    logic [31:0] ar_q_addr[$];
    int          ar_q_len[$];
    logic [31:0] ar_log_addr[$];
    int          ar_log_len[$];
    int          ar_log_edge[$];
    logic [63:0] rx_log[$];
    int          rlast_edge[$];
    int          r_beat      = 0;
    int          rx_total    = 0;
    int          bad_idx     = -1;
    int          done_cnt    = 0;
    int          done_edge   = -1;
    int          rr_err      = 0;
    int          stab_err    = 0;
    int          arvalid_cnt = 0;
    bit          r_en        = 1'b1;
    bit          ar_toggle   = 1'b0;
    bit          rdy_toggle  = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [31:0] prev_addr   = '0;
    logic [7:0]  prev_len    = '0;

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    function automatic int count_bad_data(input logic [31:0] base);
        int bad = 0;
        for (int i = 0; i < rx_log.size(); i++)
            if (rx_log[i] !== data_of(base + 32'(i) * 32'd8)) bad++;
        return bad;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // AXI slave + stream sink: drive at the falling edge, then observe what
    // the next rising edge will see.
    initial begin
        m_axi_ARREADY = 1'b1;
        m_axi_RVALID  = 1'b0;
        m_axi_RDATA   = '0;
        m_axi_RLAST   = 1'b0;
        m_axi_RRESP   = 2'b00;
        out_ready     = 1'b1;
        forever begin
            @(negedge clk);
            m_axi_ARREADY = ar_toggle  ? ~m_axi_ARREADY : 1'b1;
            out_ready     = rdy_toggle ? ~out_ready     : 1'b1;
            if (r_en && ar_q_addr.size() > 0) begin
                m_axi_RVALID = 1'b1;
                m_axi_RDATA  = data_of(ar_q_addr[0] + (32'(r_beat) << 3));
                m_axi_RLAST  = (r_beat == ar_q_len[0]);
                m_axi_RRESP  = (rx_total == bad_idx) ? 2'b10 : 2'b00;
            end else begin
                m_axi_RVALID = 1'b0;
                m_axi_RDATA  = '0;
                m_axi_RLAST  = 1'b0;
                m_axi_RRESP  = 2'b00;
            end
            #1;
            if (!rst) begin
                if (m_axi_ARVALID) arvalid_cnt++;
                if (prev_stall && (!m_axi_ARVALID || m_axi_ARADDR !== prev_addr ||
                                   m_axi_ARLEN !== prev_len)) stab_err++;
                prev_stall = m_axi_ARVALID && !m_axi_ARREADY;
                prev_addr  = m_axi_ARADDR;
                prev_len   = m_axi_ARLEN;
                if (m_axi_RREADY !== (out_ready && busy)) rr_err++;
                if (m_axi_RVALID && m_axi_RREADY) begin
                    if (out_valid !== 1'b1) rr_err++;
                    rx_log.push_back(out_data);
                    rx_total++;
                    if (m_axi_RLAST) begin
                        rlast_edge.push_back(cyc + 1);
                        void'(ar_q_addr.pop_front());
                        void'(ar_q_len.pop_front());
                        r_beat = 0;
                    end else begin
                        r_beat++;
                    end
                end
                if (m_axi_ARVALID && m_axi_ARREADY) begin
                    ar_q_addr.push_back(m_axi_ARADDR);
                    ar_q_len.push_back(int'(m_axi_ARLEN));
                    ar_log_addr.push_back(m_axi_ARADDR);
                    ar_log_len.push_back(int'(m_axi_ARLEN));
                    ar_log_edge.push_back(cyc + 1);
                end
                if (done) begin
                    done_cnt++;
                    done_edge = cyc;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        ar_log_addr.delete();
        ar_log_len.delete();
        ar_log_edge.delete();
        rx_log.delete();
        rlast_edge.delete();
        rr_err      = 0;
        stab_err    = 0;
        arvalid_cnt = 0;
    endtask

    task automatic launch(input logic [31:0] base, input logic [31:0] bytes, output int n_edge);
        base_addr     = base;
        transfer_byte = bytes;
        start         = 1'b1;
        n_edge        = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done got=none exp=done_within_%0d_cycles", name, budget);
        end else begin
            checks++;
            if (busy !== 1'b0 || m_axi_RREADY !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_idle got=busy%0b_rready%0b exp=0_0", name, busy, m_axi_RREADY);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_width got=%0b exp=0", name, done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, m_axi_ARVALID, m_axi_RREADY, out_valid, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, done, m_axi_ARVALID, m_axi_RREADY, out_valid, err});
        end
        checks++;
        if (m_axi_ARADDR !== 32'd0 || m_axi_ARLEN !== 8'd0) begin
            failures++;
            $display("FAIL reset_ar got=%h/%0d exp=0/0", m_axi_ARADDR, m_axi_ARLEN);
        end
        checks++;
        if ({m_axi_ARSIZE, m_axi_ARBURST, m_axi_ARID, m_axi_ARCACHE, m_axi_ARPROT, m_axi_ARQOS}
            !== {3'd3, 2'b01, 4'd0, 4'd0, 3'd0, 4'd0}) begin
            failures++;
            $display("FAIL ar_constants got=size%0d_burst%0d exp=size3_burst1", m_axi_ARSIZE, m_axi_ARBURST);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || m_axi_ARVALID !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=busy%0b_arvalid%0b exp=0_0", busy, m_axi_ARVALID);
        end
    endtask

    task automatic test_aligned();
        int n;
        logic [31:0] base = 32'h1000_0000;
        clear_logs();
        launch(base, 32'd2048, n);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL launch_busy_early got=%0b exp=0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || m_axi_ARVALID !== 1'b1 || m_axi_ARADDR !== base || m_axi_ARLEN !== 8'd31) begin
            failures++;
            $display("FAIL launch_ar got=busy%0b_v%0b_%h_len%0d exp=1_1_%h_len31",
                     busy, m_axi_ARVALID, m_axi_ARADDR, m_axi_ARLEN, base);
        end
        wait_done(1000, "aligned");
        checks++;
        if (ar_log_addr.size() != 8) begin
            failures++;
            $display("FAIL aligned_ar_count got=%0d exp=8", ar_log_addr.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a = (i < ar_log_addr.size()) ? ar_log_addr[i] : 32'hFFFF_FFFF;
            int          l = (i < ar_log_len.size())  ? ar_log_len[i]  : -1;
            checks++;
            if (a !== base + 32'(i) * 32'h100 || l != 31) begin
                failures++;
                $display("FAIL aligned_ar%0d got=%h/%0d exp=%h/31", i, a, l, base + 32'(i) * 32'h100);
            end
        end
        checks++;
        if (ar_log_edge.size() < 2 || ar_log_edge[0] != n + 2 || ar_log_edge[1] != n + 3) begin
            failures++;
            $display("FAIL back_to_back_ar got=%0d,%0d exp=%0d,%0d",
                     ar_log_edge.size() > 0 ? ar_log_edge[0] : -1,
                     ar_log_edge.size() > 1 ? ar_log_edge[1] : -1, n + 2, n + 3);
        end
        checks++;
        if (rx_log.size() != 256 || count_bad_data(base) != 0) begin
            failures++;
            $display("FAIL aligned_data got=%0d_beats_%0d_bad exp=256_beats_0_bad",
                     rx_log.size(), count_bad_data(base));
        end
        checks++;
        if (rlast_edge.size() != 8 || done_edge != rlast_edge[rlast_edge.size() - 1] + 1) begin
            failures++;
            $display("FAIL aligned_done_timing got=rlast%0d_done_edge%0d exp=8_rlast_plus1",
                     rlast_edge.size(), done_edge);
        end
    endtask

    task automatic test_4k_boundary();
        int n;
        logic [31:0] exp_addr[3] = '{32'h0000_0FC0, 32'h0000_1000, 32'h0000_1100};
        int          exp_len[3]  = '{7, 31, 23};
        clear_logs();
        launch(32'h0000_0FC0, 32'd512, n);
        wait_done(500, "boundary");
        checks++;
        if (ar_log_addr.size() != 3) begin
            failures++;
            $display("FAIL boundary_ar_count got=%0d exp=3", ar_log_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a = (i < ar_log_addr.size()) ? ar_log_addr[i] : 32'hFFFF_FFFF;
            int          l = (i < ar_log_len.size())  ? ar_log_len[i]  : -1;
            checks++;
            if (a !== exp_addr[i] || l != exp_len[i] || (int'(a[11:0]) + (l + 1) * 8) > 4096) begin
                failures++;
                $display("FAIL boundary_ar%0d got=%h/%0d exp=%h/%0d", i, a, l, exp_addr[i], exp_len[i]);
            end
        end
        checks++;
        if (rx_log.size() != 64 || count_bad_data(32'h0000_0FC0) != 0) begin
            failures++;
            $display("FAIL boundary_data got=%0d_beats exp=64_beats_in_order", rx_log.size());
        end
    endtask

    task automatic test_ar_backpressure();
        int n;
        logic [31:0] base = 32'h4000_0000;
        clear_logs();
        ar_toggle = 1'b1;
        launch(base, 32'd1024, n);
        wait_done(1000, "ar_bp");
        ar_toggle = 1'b0;
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL ar_hold_stable got=%0d_violations exp=0", stab_err);
        end
        checks++;
        if (ar_log_addr.size() != 4 || ar_log_addr[3] !== base + 32'h300 || ar_log_len[3] != 31) begin
            failures++;
            $display("FAIL ar_bp_bursts got=%0d exp=4_ending_at_%h", ar_log_addr.size(), base + 32'h300);
        end
        checks++;
        if (rx_log.size() != 128 || count_bad_data(base) != 0) begin
            failures++;
            $display("FAIL ar_bp_data got=%0d_beats exp=128_in_order", rx_log.size());
        end
    endtask

    task automatic test_outstanding();
        int n;
        logic [31:0] base = 32'h2000_0000;
        clear_logs();
        r_en = 1'b0;
        launch(base, 32'd2048, n);
        repeat (20) tick();
        checks++;
        if (ar_log_addr.size() != 2 || m_axi_ARVALID !== 1'b0) begin
            failures++;
            $display("FAIL outstanding_limit got=%0d_ars_arvalid%0b exp=2_ars_arvalid0",
                     ar_log_addr.size(), m_axi_ARVALID);
        end
        r_en = 1'b1;
        wait_done(1500, "outstanding");
        checks++;
        if (ar_log_edge.size() < 3 || rlast_edge.size() < 1 || ar_log_edge[2] != rlast_edge[0] + 1) begin
            failures++;
            $display("FAIL third_ar_after_rlast got=%0d exp=%0d",
                     ar_log_edge.size() > 2 ? ar_log_edge[2] : -1,
                     rlast_edge.size() > 0 ? rlast_edge[0] + 1 : -1);
        end
        checks++;
        if (ar_log_addr.size() != 8 || rx_log.size() != 256 || count_bad_data(base) != 0) begin
            failures++;
            $display("FAIL outstanding_totals got=%0d_ars_%0d_beats exp=8_ars_256_beats",
                     ar_log_addr.size(), rx_log.size());
        end
    endtask

    task automatic test_out_ready_toggle();
        int n;
        logic [31:0] base = 32'h3000_0040;
        clear_logs();
        rdy_toggle = 1'b1;
        launch(base, 32'd64, n);
        wait_done(200, "toggle");
        rdy_toggle = 1'b0;
        checks++;
        if (rr_err != 0) begin
            failures++;
            $display("FAIL rready_mirror got=%0d_bad_cycles exp=0", rr_err);
        end
        checks++;
        if (rx_log.size() != 8 || count_bad_data(base) != 0) begin
            failures++;
            $display("FAIL toggle_data got=%0d_beats exp=8_in_order", rx_log.size());
        end
        checks++;
        if (ar_log_len.size() != 1 || ar_log_len[0] != 7) begin
            failures++;
            $display("FAIL toggle_ar got=%0d_ars exp=1_ar_len7", ar_log_len.size());
        end
    endtask

    task automatic test_zero_len();
        int n;
        clear_logs();
        launch(32'h7000_0000, 32'd0, n);
        wait_done(20, "zero");
        checks++;
        if (done_edge != n + 2) begin
            failures++;
            $display("FAIL zero_done_edge got=%0d exp=%0d", done_edge, n + 2);
        end
        checks++;
        if (arvalid_cnt != 0) begin
            failures++;
            $display("FAIL zero_no_ar got=%0d_arvalid_cycles exp=0", arvalid_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        int d;
        clear_logs();
        launch(32'h5000_0000, 32'd256, n);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300, "busy_start");
        d = done_cnt;
        repeat (10) tick();
        checks++;
        if (done_cnt != d || ar_log_addr.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_while_busy got=extra_done%0d_ars%0d_busy%0b exp=0_1_0",
                     done_cnt - d, ar_log_addr.size(), busy);
        end
    endtask

    task automatic test_rresp();
        int n;
        logic exp_err;
`ifdef RDMA_RRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_logs();
        bad_idx = rx_total + 2;
        launch(32'h6000_0000, 32'd128, n);
        wait_done(200, "rresp");
        bad_idx = -1;
        checks++;
        if (err !== exp_err || rx_log.size() != 16) begin
            failures++;
            $display("FAIL rresp_err_sticky got=err%0b_beats%0d exp=err%0b_beats16", err, rx_log.size(), exp_err);
        end
        clear_logs();
        launch(32'h6000_1000, 32'd64, n);
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL rresp_err_clear got=%0b exp=0", err);
        end
        wait_done(200, "rresp_clean");
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL rresp_clean_run got=%0b exp=0", err);
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        transfer_byte = '0;
        test_reset();
        test_aligned();
        test_4k_boundary();
        test_ar_backpressure();
        test_outstanding();
        test_out_ready_toggle();
        test_zero_len();
        test_start_while_busy();
        test_rresp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rdma_burst_engine.md
# rdma_burst_engine

Parametrised AXI4 read-DMA engine, the successor to the fixed 64-bit single-stream read DMA. It fetches `transfer_byte` bytes starting at `base_addr` through one AXI4 read master and splits the request into INCR bursts that never cross a 4 KB boundary. It keeps up to `MAX_OUTSTANDING` bursts in flight and delivers read data on a valid/ready stream with full backpressure. It sits between the memory interconnect and the on-chip feature/weight buffers.

## Interface
- `DATA_W`, 64: AXI and stream data width in bits; one of 32, 64, 128.
- `ADDR_W`, 32: address width.
- `MAX_BURST`, 32: maximum beats per burst; range 1..256.
- `MAX_OUTSTANDING`, 4: maximum accepted ARs awaiting RLAST; range 1..16.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level input; its rising edge launches a transfer.
- `base_addr` in ADDR_W: start address; must be aligned to DATA_W/8.
- `transfer_byte` in 32: byte count; must be a multiple of DATA_W/8.
- `busy` out 1: high from launch until done.
- `done` out 1: one-cycle pulse at completion.
- `out_data` out DATA_W: read data.
- `out_valid` out 1: read data valid.
- `out_ready` in 1: downstream ready.
- `m_axi_ARVALID`/`ARREADY`/`ARADDR[ADDR_W]`/`ARLEN[8]`: AR channel.
- `ARSIZE`, `ARBURST`, `ARID`, `ARCACHE`, `ARPROT`, `ARQOS`: constant outputs. `ARSIZE` = log2(DATA_W/8), `ARBURST` = 01, all others 0.
- `m_axi_RVALID`/`RREADY`/`RDATA[DATA_W]`/`RLAST`/`RRESP[2]`: R channel.
- `err` out 1: sticky error flag (see Configuration).

## Operation
- Main FSM states:
  - IDLE → ISSUE on a rising edge of `start`. On this edge, latch `base_addr`, and set `beats_left = transfer_byte / (DATA_W/8)` and `beats_rx` from the same value.
  - If `beats_left` is 0, go IDLE → DONE directly.
  - ISSUE → DRAIN on the AR handshake of the final burst.
  - DRAIN → DONE when the RLAST handshake leaves `beats_rx` = 0.
  - DONE → IDLE after exactly 1 cycle.
- Burst length = min(`beats_left`, `MAX_BURST`, `(4096 − addr[11:0]) / (DATA_W/8)`). `ARLEN` = length − 1.
- On each AR handshake: `addr += length*(DATA_W/8)`, `beats_left −= length`, `outstanding += 1`.
- `ARVALID` = (state == ISSUE) && (`outstanding` < `MAX_OUTSTANDING`).
- `outstanding` decrements on every RLAST handshake. If an AR handshake and an RLAST handshake occur in the same cycle, `outstanding` is unchanged.
- R path is combinational: `out_data` = `RDATA`, `out_valid` = `RVALID` && `busy`, `RREADY` = `out_ready` && `busy`. Each R handshake decrements `beats_rx`.
- A `start` rising edge while `busy` is high is ignored; the edge detector still tracks the level.
- Address arithmetic wraps modulo 2^ADDR_W, with no error. Misaligned or non-multiple inputs are undefined.

## Timing
- Reset values:
  - FSM = IDLE; `busy` = 0; `done` = 0; `ARVALID` = 0.
  - `ARADDR` = 0; `ARLEN` = 0; `RREADY` = 0; `out_valid` = 0; `err` = 0.
  - All counters = 0; the edge detector's previous sample = 0.
- Launch: `start` is seen high at edge N (previous sample 0). At edge N+1, `busy` = 1 and `ARVALID` = 1 with `ARADDR` = `base_addr`.
- `ARADDR`/`ARLEN` are registered and hold stable while `ARVALID && !ARREADY`.
- Back-to-back ARs: after a handshake at edge K, the next burst's values are presented from edge K onward, so a second handshake can occur at edge K+1.
- Completion: final RLAST handshake at edge M. At edge M+1, `done` = 1, `busy` = 0, `RREADY` = 0. At edge M+2, `done` = 0.
- Zero-length launch: `done` pulses at N+2, with no AR issued.
- `rst` asserted mid-transfer clears all state immediately. In-flight AXI beats are not tracked afterwards; the integrator must quiesce the bus.

## Configuration
- `RDMA_RRESP_CHECK_EN` defined:
  - Any R handshake with `RRESP` ≠ 00 sets `err`.
  - `err` clears only on the next accepted launch or on `rst`.
  - The transfer still runs to completion.
- `RDMA_RRESP_CHECK_EN` undefined: `err` is tied to 0 and `RRESP` is ignored.

## Test plan
- DATA_W=64, base 0x1000_0000, 2048 bytes, `ARREADY`/`out_ready` always 1 → 8 ARs, each `ARLEN` = 31, addresses step 0x100; 256 beats delivered; `done` one cycle after the final RLAST.
- base 0x0000_0FC0, 512 bytes, DATA_W=64 → first AR at 0xFC0 with `ARLEN` 7; then 0x1000 with `ARLEN` 31; then 0x1100 with `ARLEN` 23; no burst crosses 4 KB.
- MAX_OUTSTANDING=2, R channel stalled, 8 bursts queued → exactly 2 AR handshakes, `ARVALID` low afterwards; releasing the first RLAST allows the third AR.
- `out_ready` toggled 1-0-1 every cycle, 64 bytes → `RREADY` mirrors `out_ready`; exactly 8 beats counted; data order preserved.
- `transfer_byte` = 0 → no `ARVALID`; `done` pulses at N+2. A second `start` edge while `busy` → ignored, so only one `done`.
- With `RDMA_RRESP_CHECK_EN`: one beat returns `RRESP` = 10 → `err` = 1 sticky through `done`; the next launch clears it.
